// File: rtl/fetch_issue_queue_way0_pkg.sv
// Decode/issue types and constants shared by the fetch issue queue and both decode ways.
package fetch_issue_queue_way0_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int PID_W  = 2;

    localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] addr;
        logic [PID_W-1:0]  pid;
    } issue_entry_t;

endpackage

// File: rtl/fetch_issue_queue_way0_mem.sv
// Register-file storage for the issue queue: one synchronous write port, one asynchronous read port.
module issue_queue_mem
    import fetch_issue_queue_way0_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_ptr_i,
    input  issue_entry_t             wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
    output issue_entry_t             rd_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    issue_entry_t mem_q [DEPTH];

    // Contents are don't-care after reset, so entries carry no reset.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (wr_en_i && (wr_ptr_i == PTR_W'(gi))) begin
                mem_q[gi] <= wr_data_i;
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/fetch_issue_queue_way0.sv
// In-order instruction buffer feeding the way0 decoder over a valid/ready/pID handshake.
module fetch_issue_queue_way0
    import fetch_issue_queue_way0_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     fetchValid_i,
    input  logic [INST_W-1:0]        fetchInst_i,
    input  logic [ADDR_W-1:0]        fetchAddr_i,
    output logic                     fetchReady_o,
    output logic                     valid_o,
    output logic [INST_W-1:0]        inst_o,
    output logic [ADDR_W-1:0]        instAddr_o,
    output logic [PID_W-1:0]         way0_pID_o,
    input  logic                     ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PID_W-1:0] pid_cnt_q, pid_cnt_d;

    logic         not_full;
    logic         not_empty;
    logic         enq;
    logic         deq;
    issue_entry_t wr_entry;
    issue_entry_t rd_entry;

    // Full/empty come from the occupancy count only, keeping ready_i off the fetch-ready path.
    assign not_full  = (count_q != CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);
    assign enq       = fetchValid_i && not_full && !flush_i;
    assign deq       = not_empty && ready_i && !flush_i;

    assign wr_entry  = '{inst: fetchInst_i, addr: fetchAddr_i, pid: pid_cnt_q};

    issue_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (enq),
        .wr_ptr_i  (tail_q),
        .wr_data_i (wr_entry),
        .rd_ptr_i  (head_q),
        .rd_data_o (rd_entry)
    );

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pid_cnt_d = pid_cnt_q;
        if (flush_i) begin
            // The pID counter keeps running across a flush so the decoder sees a continuous sequence.
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) begin
                tail_d    = tail_q + 1'b1;
                pid_cnt_d = pid_cnt_q + 1'b1;
            end
            if (deq) begin
                head_d = head_q + 1'b1;
            end
            if (enq && !deq) begin
                count_d = count_q + 1'b1;
            end else if (deq && !enq) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pid_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pid_cnt_q <= pid_cnt_d;
        end
    end

    assign fetchReady_o = not_full;
    assign valid_o      = not_empty;
    assign inst_o       = not_empty ? rd_entry.inst : NOP_INST;
    assign instAddr_o   = not_empty ? rd_entry.addr : '0;
    assign way0_pID_o   = not_empty ? rd_entry.pid  : '0;
    assign count_o      = count_q;

endmodule

// File: tb/tb_fetch_issue_queue_way0.sv
// Directed and random stimulus against a queue-based reference model of the issue buffer.
module tb_fetch_issue_queue_way0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        fetchValid_i = 1'b0;
    logic [31:0] fetchInst_i = '0;
    logic [31:0] fetchAddr_i = '0;
    logic        fetchReady_o;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] instAddr_o;
    logic [1:0]  way0_pID_o;
    logic        ready_i = 1'b0;
    logic [2:0]  count_o;

    fetch_issue_queue_way0 #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .fetchValid_i (fetchValid_i),
        .fetchInst_i  (fetchInst_i),
        .fetchAddr_i  (fetchAddr_i),
        .fetchReady_o (fetchReady_o),
        .valid_o      (valid_o),
        .inst_o       (inst_o),
        .instAddr_o   (instAddr_o),
        .way0_pID_o   (way0_pID_o),
        .ready_i      (ready_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        int unsigned pid;
    } ent_t;

    ent_t        mq[$];
    int unsigned pid_m = 0;
    bit          model_valid = 0;
    bit          last_enq = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (mq.size() != 0);
        chk("fetchReady", 64'(fetchReady_o), 64'(mq.size() != 4));
        chk("valid",      64'(valid_o),      64'(v));
        chk("count",      64'(count_o),      64'(mq.size()));
        chk("inst",       64'(inst_o),       v ? 64'(mq[0].inst) : 64'h13);
        chk("addr",       64'(instAddr_o),   v ? 64'(mq[0].addr) : 64'h0);
        chk("pid",        64'(way0_pID_o),   v ? 64'(mq[0].pid % 4) : 64'h0);
    endtask

    // One cycle: check state-derived outputs, drive inputs, then advance the model on the edge.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] i, input logic [31:0] a, input logic rd);
        bit m_enq, m_deq;
        @(negedge clk);
        if (model_valid) check_outputs();
        rst_n = r; flush_i = f; fetchValid_i = v;
        fetchInst_i = i; fetchAddr_i = a; ready_i = rd;
        @(posedge clk);
        m_enq = v && (mq.size() != 4) && !f;
        m_deq = (mq.size() != 0) && rd && !f;
        last_enq = 0;
        if (!r) begin
            mq.delete();
            pid_m = 0;
            model_valid = 1;
        end else if (f) begin
            mq.delete();
        end else begin
            if (m_deq) void'(mq.pop_front());
            if (m_enq) begin
                mq.push_back('{inst: i, addr: a, pid: pid_m});
                pid_m++;
                last_enq = 1;
            end
        end
        $display("cyc rst_n=%0b flush=%0b fv=%0b inst=%h rdy=%0b -> model count=%0d", r, f, v, i, rd, mq.size());
    endtask

    task automatic idle(input logic rd);
        step(1, 0, 0, 32'h0, 32'h0, rd);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 32'h0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 32'h0, 0);
    endtask

    initial begin
        int n;
        int guard;
        bit tog;
        logic [31:0] stream_inst [3];
        stream_inst[0] = 32'h00500093;
        stream_inst[1] = 32'h00A00113;
        stream_inst[2] = 32'h002081B3;

        // Reset then idle
        do_reset();
        idle(0);
        idle(0);

        // Streaming with ready_i held high
        for (int k = 0; k < 3; k++) step(1, 0, 1, stream_inst[k], 32'h80000000 + 32'(4 * k), 1);
        repeat (3) idle(1);

        // Fill under backpressure, then release
        do_reset();
        for (int k = 0; k < 6; k++) step(1, 0, 1, $urandom, 32'h80001000 + 32'(4 * k), 0);
        repeat (2) idle(0);
        repeat (6) idle(1);

        // Simultaneous enqueue and dequeue at count 2
        do_reset();
        step(1, 0, 1, 32'h11111111, 32'h100, 0);
        step(1, 0, 1, 32'h22222222, 32'h104, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 1, $urandom, 32'h108 + 32'(4 * k), 1);
        repeat (4) idle(1);

        // Wrap-around with ready_i toggling every cycle
        do_reset();
        n = 0; guard = 0; tog = 0;
        while (n < 10 && guard < 100) begin
            step(1, 0, 1, 32'hA0000000 + 32'(n), 32'h2000 + 32'(4 * n), tog);
            if (last_enq) n++;
            tog = ~tog;
            guard++;
        end
        chk("wrap_enq_budget", 64'(n), 64'd10);
        repeat (8) begin
            idle(tog);
            tog = ~tog;
        end

        // Flush with a concurrent fetch; pID continues afterwards
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 1, 32'hB0 + 32'(k), 32'h3000 + 32'(4 * k), 0);
        step(1, 1, 1, 32'hDEADBEEF, 32'h3100, 1);
        idle(0);
        step(1, 0, 1, 32'hC0FFEE01, 32'h3200, 0);
        #1;
        chk("post_flush_valid", 64'(valid_o), 64'd1);
        chk("post_flush_pid",   64'(way0_pID_o), 64'd3);
        chk("post_flush_inst",  64'(inst_o), 64'hC0FFEE01);

        // Reset in the same cycle as flush clears the pID counter
        for (int k = 0; k < 2; k++) step(1, 0, 1, 32'hD0 + 32'(k), 32'h4000 + 32'(4 * k), 0);
        step(0, 1, 1, 32'hDEADBEEF, 32'h4100, 1);
        idle(0);
        step(1, 0, 1, 32'hC0FFEE02, 32'h4200, 0);
        #1;
        chk("post_reset_pid",  64'(way0_pID_o), 64'd0);
        chk("post_reset_inst", 64'(inst_o), 64'hC0FFEE02);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(99) != 0), ($urandom_range(29) == 0),
                 ($urandom_range(9) < 7), $urandom, $urandom, $urandom_range(1));
        end
        repeat (6) idle(1);
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
